// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive-side checker for the N-bit LFSR
// pattern generator. It hunts for a seed, confirms it over a few words, then
// flywheels against the predicted sequence and reports errors and full periods.
module lfsr_checker #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             clear_stats,
  output logic             locked,
  output logic             error,
  output logic             period_done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned RUN_W = 4;

  // Feedback taps of the generator polynomial for each supported width.
  function automatic logic [7:0] tap_mask(input int unsigned n);
    case (n)
      2:       return 8'h03;
      3:       return 8'h06;
      4:       return 8'h0C;
      5:       return 8'h14;
      6:       return 8'h30;
      7:       return 8'h60;
      8:       return 8'hB8;
      default: return 8'h0C;
    endcase
  endfunction

  localparam logic [7:0]   TAPS8 = tap_mask(N);
  localparam logic [N-1:0] TAPS  = TAPS8[N-1:0];

  // Generator next-state: shift left, XOR of tapped bits into bit 0.
  function automatic logic [N-1:0] nxt(input logic [N-1:0] x);
    return {x[N-2:0], ^(x & TAPS)};
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_expected, w_expected_nxt;
  logic [N-1:0]     r_ref, w_ref_nxt;
  logic [RUN_W-1:0] r_match_run, w_match_run_nxt;
  logic [RUN_W-1:0] r_miss_run, w_miss_run_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_error, w_error_nxt;
  logic             r_period_done, w_period_done_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] r_word_count, w_word_count_nxt;

  logic             w_is_zero;
  logic             w_hit;
  logic [RUN_W-1:0] w_match_inc;
  logic [RUN_W-1:0] w_miss_inc;

  assign w_is_zero   = (in_data == '0);
  assign w_hit       = (in_data == r_expected);
  assign w_match_inc = r_match_run + RUN_W'(1);
  assign w_miss_inc  = r_miss_run + RUN_W'(1);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= HUNT;
      r_expected    <= '0;
      r_ref         <= '0;
      r_match_run   <= '0;
      r_miss_run    <= '0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_period_done <= 1'b0;
      r_err_count   <= '0;
      r_word_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_expected    <= w_expected_nxt;
      r_ref         <= w_ref_nxt;
      r_match_run   <= w_match_run_nxt;
      r_miss_run    <= w_miss_run_nxt;
      r_locked      <= w_locked_nxt;
      r_error       <= w_error_nxt;
      r_period_done <= w_period_done_nxt;
      r_err_count   <= w_err_count_nxt;
      r_word_count  <= w_word_count_nxt;
    end
  end

  // Next-state, prediction, run counters, pulses and statistics.
  always_comb begin
    w_state_nxt       = r_state;
    w_expected_nxt    = r_expected;
    w_ref_nxt         = r_ref;
    w_match_run_nxt   = r_match_run;
    w_miss_run_nxt    = r_miss_run;
    w_error_nxt       = 1'b0;
    w_period_done_nxt = 1'b0;
    w_err_count_nxt   = r_err_count;
    w_word_count_nxt  = r_word_count;

    if (in_valid) begin
      case (r_state)
        HUNT: begin
          // All-zero word is the generator lock-up state and never seeds.
          if (!w_is_zero) begin
            w_expected_nxt  = nxt(in_data);
            w_match_run_nxt = '0;
            w_state_nxt     = VERIFY;
          end
        end
        VERIFY: begin
          if (w_hit) begin
            w_expected_nxt  = nxt(in_data);
            w_match_run_nxt = w_match_inc;
            if (w_match_inc == RUN_W'(LOCK_CNT)) begin
              w_state_nxt    = LOCKED;
              w_ref_nxt      = in_data;
              w_miss_run_nxt = '0;
            end
          end else begin
            w_match_run_nxt = '0;
            w_expected_nxt  = nxt(in_data);
            if (w_is_zero) begin
              w_state_nxt = HUNT;
            end
          end
        end
        LOCKED: begin
          w_word_count_nxt = sat_inc(r_word_count);
          if (w_hit) begin
            w_expected_nxt    = nxt(in_data);
            w_miss_run_nxt    = '0;
            w_period_done_nxt = (in_data == r_ref);
          end else begin
            // Flywheel on the prediction; a bad word never re-seeds while locked.
            w_error_nxt     = 1'b1;
            w_err_count_nxt = sat_inc(r_err_count);
            w_expected_nxt  = nxt(r_expected);
            w_miss_run_nxt  = w_miss_inc;
            if (w_miss_inc == RUN_W'(LOSS_CNT)) begin
              w_state_nxt = HUNT;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end

    if (clear_stats) begin
      w_err_count_nxt  = '0;
      w_word_count_nxt = '0;
    end

    w_locked_nxt = (w_state_nxt == LOCKED);
  end

  assign locked      = r_locked;
  assign error       = r_error;
  assign period_done = r_period_done;
  assign err_count   = r_err_count;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scenarios for lfsr_checker at N=4 against the
// hand-derived 15-word generator sequence starting from seed 1111.
module tb_lfsr_checker;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             clear_stats;
  logic             locked;
  logic             error;
  logic             period_done;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] word_count;

  int checks   = 0;
  int failures = 0;
  int idx      = 0;

  // Generator output from seed 1111 with taps x3^x2, one full period.
  logic [N-1:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                             4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  lfsr_checker #(.N(N), .LOCK_CNT(3), .LOSS_CNT(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clear_stats (clear_stats),
    .locked      (locked),
    .error       (error),
    .period_done (period_done),
    .err_count   (err_count),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic send(input logic [N-1:0] d, input logic v, input logic clr);
    in_data     = d;
    in_valid    = v;
    clear_stats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_next();
    send(seq[idx], 1'b1, 1'b0);
    idx = (idx + 1) % 15;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", error); end
    checks++; if (period_done !== 1'b0) begin failures++; $display("FAIL reset_period_done got=%0b exp=0", period_done); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      send_next();
      checks++;
      if (locked !== (k == 3)) begin
        failures++; $display("FAIL lock_step%0d got=%0b exp=%0b", k, locked, (k == 3));
      end
    end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL lock_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_period();
    for (int k = 1; k <= 15; k++) begin
      send_next();
      checks++;
      if (period_done !== (k == 15)) begin
        failures++; $display("FAIL period_pulse word%0d got=%0b exp=%0b", k, period_done, (k == 15));
      end
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL period_error word%0d got=%0b exp=0", k, error); end
    end
    checks++; if (word_count !== 16'd15) begin failures++; $display("FAIL period_word_count got=%0d exp=15", word_count); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL period_locked got=%0b exp=1", locked); end
  endtask

  task automatic test_single_error();
    send(4'h0, 1'b1, 1'b0);  // replaces 0001
    idx = (idx + 1) % 15;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL single_error_pulse got=%0b exp=1", error); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL single_err_count got=%0d exp=1", err_count); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL single_locked got=%0b exp=1", locked); end
    send_next();             // 0010 via flywheel
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL single_flywheel_error got=%0b exp=0", error); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL single_flywheel_locked got=%0b exp=1", locked); end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 3; k++) begin
      send(4'hF, 1'b0, 1'b0);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL gap%0d_error got=%0b exp=0", k, error); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap%0d_locked got=%0b exp=1", k, locked); end
      checks++; if (word_count !== 16'd17) begin failures++; $display("FAIL gap%0d_word_count got=%0d exp=17", k, word_count); end
    end
    send_next();             // 0100
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL gap_resume_error got=%0b exp=0", error); end
    checks++; if (word_count !== 16'd18) begin failures++; $display("FAIL gap_resume_word_count got=%0d exp=18", word_count); end
  endtask

  task automatic test_loss();
    for (int k = 0; k < 4; k++) begin
      send(4'h0, 1'b1, 1'b0);
      idx = (idx + 1) % 15;
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL loss%0d_error got=%0b exp=1", k, error); end
      checks++;
      if (locked !== (k < 3)) begin failures++; $display("FAIL loss%0d_locked got=%0b exp=%0b", k, locked, (k < 3)); end
    end
    checks++; if (err_count !== 16'd5) begin failures++; $display("FAIL loss_err_count got=%0d exp=5", err_count); end
    for (int k = 0; k < 4; k++) begin
      send_next();
      checks++;
      if (locked !== (k == 3)) begin failures++; $display("FAIL relock%0d_locked got=%0b exp=%0b", k, locked, (k == 3)); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL relock%0d_error got=%0b exp=0", k, error); end
    end
    checks++; if (err_count !== 16'd5) begin failures++; $display("FAIL relock_err_count got=%0d exp=5", err_count); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL async_locked got=%0b exp=0", locked); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL async_err_count got=%0d exp=0", err_count); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL async_word_count got=%0d exp=0", word_count); end
    #2 reset = 1'b0;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      send_next();
      checks++;
      if (locked !== (k == 3)) begin failures++; $display("FAIL async_relock%0d got=%0b exp=%0b", k, locked, (k == 3)); end
    end
    send(4'h0, 1'b1, 1'b1);  // mismatch with clear_stats on the same edge
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL clear_error got=%0b exp=1", error); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clear_err_count got=%0d exp=0", err_count); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL clear_word_count got=%0d exp=0", word_count); end
    send(4'h0, 1'b1, 1'b0);  // mismatch without clear
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL post_clear_err_count got=%0d exp=1", err_count); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL post_clear_locked got=%0b exp=1", locked); end
  endtask

  task automatic test_zero_stream();
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(4'h0, 1'b1, 1'b0);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL zero%0d_locked got=%0b exp=0", k, locked); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL zero%0d_error got=%0b exp=0", k, error); end
    end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL zero_word_count got=%0d exp=0", word_count); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_period();
    test_single_error();
    test_gaps();
    test_loss();
    test_async_reset();
    test_zero_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
